// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - execute-stage types and multiply opcode selection
package exec_pkg;

   localparam int MUL_WIDTH = 64;

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} mul_state_t;

   // One-byte opcodes that route to the multiply sequencer
   localparam logic [7:0] OPC_GRP3      = 8'hF7;   // ModRM.reg selects MUL or IMUL
   localparam logic [2:0] GRP3_REG_MUL  = 3'd4;
   localparam logic [2:0] GRP3_REG_IMUL = 3'd5;
   localparam logic [7:0] OPC_IMUL_IB   = 8'h6B;   // IMUL r, r/m, imm8
   localparam logic [7:0] OPC_IMUL_IZ   = 8'h69;   // IMUL r, r/m, imm
   // Two-byte form 0F AF: IMUL r, r/m
   localparam logic [7:0] OPC_ESC       = 8'h0F;
   localparam logic [7:0] OPC_IMUL_RM   = 8'hAF;

   // True when execute should hand the instruction to the sequencer
   function automatic logic uses_mul_seq(input logic       two_byte,
                                         input logic [7:0] opc,
                                         input logic [2:0] modrm_reg);
      if (two_byte)
         return opc == OPC_IMUL_RM;
      return ((opc == OPC_GRP3) &&
              ((modrm_reg == GRP3_REG_MUL) || (modrm_reg == GRP3_REG_IMUL))) ||
             (opc == OPC_IMUL_IB) || (opc == OPC_IMUL_IZ);
   endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one radix-2^STEP_BITS accumulate step of the iterative multiplier
module mul_step #(
   parameter int WIDTH     = 64,
   parameter int STEP_BITS = 4,
   parameter int CNT_W     = 4
) (
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     mag_i,
   input  logic [STEP_BITS-1:0] slice_i,
   input  logic [CNT_W-1:0]     count_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH+STEP_BITS-1:0] pp;
   logic [2*WIDTH-1:0]         partial;

   // Partial product of the magnitude and one multiplier digit, aligned to that digit's weight
   always_comb begin
      pp      = (WIDTH+STEP_BITS)'(mag_i) * (WIDTH+STEP_BITS)'(slice_i);
      partial = (2*WIDTH)'(pp);
      acc_o   = acc_i + (partial << (STEP_BITS * int'(count_i)));
   end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle MUL/IMUL sequencer beside the execute stage
module mul_sequencer
   import exec_pkg::*;
#(
   parameter int WIDTH     = MUL_WIDTH,
   parameter int STEP_BITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startIn,
   input  logic             signedIn,
   input  logic [0:WIDTH-1] operandAIn,
   input  logic [0:WIDTH-1] operandBIn,
   input  logic             flushIn,
   input  logic             resultAckIn,
   output logic             readyOut,
   output logic             busyOut,
   output logic             resultValidOut,
   output logic [0:WIDTH-1] productLoOut,
   output logic [0:WIDTH-1] productHiOut
);

   localparam int ITERS = WIDTH / STEP_BITS;
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   mul_state_t           state_q, state_d;
   logic [WIDTH-1:0]     a_q, b_q;       // raw operands until PREP, magnitudes after
   logic                 signed_q;
   logic                 neg_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic [2*WIDTH-1:0]   acc_d;

   mul_step #(
      .WIDTH     (WIDTH),
      .STEP_BITS (STEP_BITS),
      .CNT_W     (CNT_W)
   ) u_step (
      .acc_i   (acc_q),
      .mag_i   (a_q),
      .slice_i (b_q[STEP_BITS-1:0]),
      .count_i (cnt_q),
      .acc_o   (acc_d)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state and status outputs; flush overrides every transition
   always_comb begin
      state_d        = state_q;
      readyOut       = 1'b0;
      busyOut        = 1'b1;
      resultValidOut = 1'b0;
      case (state_q)
         IDLE: begin
            readyOut = 1'b1;
            busyOut  = 1'b0;
            if (startIn && !flushIn)
               state_d = PREP;
         end
         PREP: state_d = ITER;
         ITER: if (cnt_q == LAST_CNT) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: begin
            resultValidOut = 1'b1;
            if (resultAckIn)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flushIn)
         state_d = IDLE;
   end

   // Operand latch, sign handling, accumulation and product register; frozen during a flush
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
      end else if (!flushIn) begin
         case (state_q)
            IDLE: begin
               if (startIn) begin
                  a_q      <= operandAIn;
                  b_q      <= operandBIn;
                  signed_q <= signedIn;
               end
            end
            PREP: begin
               // The most negative value maps to 2^(WIDTH-1), still representable unsigned
               a_q   <= (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
               b_q   <= (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
               neg_q <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               acc_q <= '0;
               cnt_q <= '0;
            end
            ITER: begin
               acc_q <= acc_d;
               b_q   <= b_q >> STEP_BITS;
               cnt_q <= cnt_q + 1'b1;
            end
            FIX: prod_q <= neg_q ? -acc_q : acc_q;
            default: ;
         endcase
      end
   end

   assign productHiOut = prod_q[2*WIDTH-1:WIDTH];
   assign productLoOut = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         startIn;
   logic         signedIn;
   logic [W-1:0] opA;
   logic [W-1:0] opB;
   logic         flushIn;
   logic         resultAckIn;
   logic         readyOut;
   logic         busyOut;
   logic         resultValidOut;
   logic [W-1:0] lo;
   logic [W-1:0] hi;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mul_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .startIn        (startIn),
      .signedIn       (signedIn),
      .operandAIn     (opA),
      .operandBIn     (opB),
      .flushIn        (flushIn),
      .resultAckIn    (resultAckIn),
      .readyOut       (readyOut),
      .busyOut        (busyOut),
      .resultValidOut (resultValidOut),
      .productLoOut   (lo),
      .productHiOut   (hi)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference product from plain integer arithmetic
   function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic sgn);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      if (sgn) begin
         sa = {{64{a[63]}}, a};
         sb = {{64{b[63]}}, b};
         return sa * sb;
      end
      return {64'd0, a} * {64'd0, b};
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'($urandom_range(0, 300));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Issue one op, scramble inputs after acceptance, check latency/product, ack at once
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sgn, input logic [127:0] exp);
      int cyc;
      opA = a; opB = b; signedIn = sgn; startIn = 1'b1;
      step();
      startIn = 1'b0;
      opA = {$urandom, $urandom};
      opB = {$urandom, $urandom};
      signedIn = ~sgn;
      cyc = 1;
      while (!resultValidOut && cyc < 40) begin
         step();
         cyc++;
      end
      check({tag, " latency"}, 128'(cyc), 128'd19);
      check({tag, " hi"}, {64'd0, hi}, {64'd0, exp[127:64]});
      check({tag, " lo"}, {64'd0, lo}, {64'd0, exp[63:0]});
      resultAckIn = 1'b1;
      step();
      resultAckIn = 1'b0;
      check({tag, " ready after ack"}, {127'd0, readyOut}, 128'd1);
      check({tag, " valid after ack"}, {127'd0, resultValidOut}, 128'd0);
   endtask

   initial begin
      logic [63:0]  ra, rb;
      logic         rs;
      logic [63:0]  held_lo, held_hi;
      logic         seen_valid;
      int           cyc;

      reset = 1'b1; startIn = 1'b0; signedIn = 1'b0; opA = '0; opB = '0;
      flushIn = 1'b0; resultAckIn = 1'b0;
      step();
      step();
      check("reset ready", {127'd0, readyOut}, 128'd1);
      check("reset busy",  {127'd0, busyOut}, 128'd0);
      check("reset valid", {127'd0, resultValidOut}, 128'd0);
      check("reset lo",    {64'd0, lo}, 128'd0);
      check("reset hi",    {64'd0, hi}, 128'd0);
      reset = 1'b0;
      step();

      // Directed products
      run_op("u3x5", 64'd3, 64'd5, 1'b0, 128'hF);
      run_op("umax_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
      run_op("s-2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1,
             {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA});
      run_op("s-1x-1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1);
      run_op("smin_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
             {64'h4000_0000_0000_0000, 64'h0});
      run_op("u0x0", 64'd0, 64'd0, 1'b0, 128'd0);

      // Flush in cycle 8 of an operation
      opA = 64'd123; opB = 64'd456; signedIn = 1'b0; startIn = 1'b1;
      step();
      startIn = 1'b0;
      for (int i = 1; i < 8; i++) step();
      flushIn = 1'b1;
      step();
      flushIn = 1'b0;
      check("flush ready", {127'd0, readyOut}, 128'd1);
      check("flush busy",  {127'd0, busyOut}, 128'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (resultValidOut) seen_valid = 1'b1;
         step();
      end
      check("flush no result", {127'd0, seen_valid}, 128'd0);
      run_op("u7x6", 64'd7, 64'd6, 1'b0, 128'd42);

      // Flush and start together in IDLE: start dropped
      opA = 64'd9; opB = 64'd9; startIn = 1'b1; flushIn = 1'b1;
      step();
      startIn = 1'b0; flushIn = 1'b0;
      check("flush+start ready", {127'd0, readyOut}, 128'd1);
      check("flush+start busy",  {127'd0, busyOut}, 128'd0);

      // Ack outside DONE has no effect
      resultAckIn = 1'b1;
      step();
      resultAckIn = 1'b0;
      check("idle ack ready", {127'd0, readyOut}, 128'd1);

      // Hold result in DONE while start pulses
      opA = 64'd9; opB = 64'd11; signedIn = 1'b0; startIn = 1'b1;
      step();
      startIn = 1'b0;
      cyc = 1;
      while (!resultValidOut && cyc < 40) begin
         step();
         cyc++;
      end
      check("hold latency", 128'(cyc), 128'd19);
      held_lo = lo; held_hi = hi;
      check("hold product", {hi, lo}, 128'd99);
      for (int i = 0; i < 5; i++) begin
         startIn = ~startIn;
         opA = {$urandom, $urandom};
         step();
         check("hold valid", {127'd0, resultValidOut}, 128'd1);
         check("hold ready", {127'd0, readyOut}, 128'd0);
         check("hold stable", {hi, lo}, {held_hi, held_lo});
      end
      startIn = 1'b0;
      resultAckIn = 1'b1;
      step();
      resultAckIn = 1'b0;
      check("hold ack ready", {127'd0, readyOut}, 128'd1);

      // Reset in the middle of ITER
      opA = 64'd1000; opB = 64'd77; startIn = 1'b1;
      step();
      startIn = 1'b0;
      for (int i = 1; i < 6; i++) step();
      reset = 1'b1;
      step();
      check("midreset ready", {127'd0, readyOut}, 128'd1);
      check("midreset busy",  {127'd0, busyOut}, 128'd0);
      check("midreset valid", {127'd0, resultValidOut}, 128'd0);
      check("midreset prod",  {hi, lo}, 128'd0);
      reset = 1'b0;
      step();

      // Randomized operands against the arithmetic model
      for (int n = 0; n < 30; n++) begin
         ra = pick();
         rb = pick();
         rs = 1'($urandom_range(0, 1));
         run_op($sformatf("rand%0d", n), ra, rb, rs, model(ra, rb, rs));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
